checkpoint_scan_ctrl: RTL

- Hardware-side checkpoint engine for the emulated design.
- Save mode: halts the emulated clock, shifts the FF scan chain and then the memory scan chain out as a word stream, and produces the checkpoint image (FF words first, then memory words) that replay and reconstruction consume.
- Load mode: accepts a word stream and shifts it into both chains.
- Sits between the host/DMA stream and the emu_top scan-chain ports.

---
 rtl/checkpoint_scan_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/checkpoint_scan_ctrl.sv
// Checkpoint engine: halts the emulated clock and streams the FF then memory scan chains
// out (save) or in (load), one word per shift-enable pulse.
module checkpoint_scan_ctrl #(
    parameter int unsigned LOAD_WIDTH = 64,
    parameter int unsigned FF_WORDS   = 16,
    parameter int unsigned MEM_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    output logic                  busy,
    output logic                  done,
    output logic                  halt_req,
    input  logic                  halted,
    output logic                  ff_se,
    output logic [LOAD_WIDTH-1:0] ff_di,
    input  logic [LOAD_WIDTH-1:0] ff_do,
    output logic                  mem_se,
    output logic [LOAD_WIDTH-1:0] mem_di,
    input  logic [LOAD_WIDTH-1:0] mem_do,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LOAD_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LOAD_WIDTH-1:0] in_data
);

    localparam int unsigned MaxWords = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
    localparam int unsigned CntW     = (MaxWords > 1) ? $clog2(MaxWords) : 1;
    localparam logic [CntW-1:0] FfLast  = CntW'(FF_WORDS - 1);
    localparam logic [CntW-1:0] MemLast = CntW'((MEM_WORDS == 0) ? 0 : MEM_WORDS - 1);
    localparam bit NoMem = (MEM_WORDS == 0);

    typedef enum logic [2:0] {
        StIdle, StHalt, StFf, StMem, StFlush, StResume, StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  halt_req_q, halt_req_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [LOAD_WIDTH-1:0] out_data_q, out_data_d;

    logic                  in_ff;
    logic                  shift;
    logic                  chain_last;
    logic                  img_last;
    logic                  take;
    logic [LOAD_WIDTH-1:0] head;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        ff_se       = 1'b0;
        mem_se      = 1'b0;
        ff_di       = '0;
        mem_di      = '0;
        in_ready    = 1'b0;
        in_ff       = (state_q == StFf);
        shift       = 1'b0;
        chain_last  = in_ff ? (cnt_q == FfLast) : (cnt_q == MemLast);
        img_last    = in_ff ? (NoMem && chain_last) : chain_last;
        head        = in_ff ? ff_do : mem_do;
        take        = out_valid_q && out_ready;

        // A drained word empties the buffer unless a fresh shift refills it below.
        if (take) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (halted) begin
                    state_d = StFf;
                end
            end
            StFf, StMem: begin
                if (mode_q) begin
                    in_ready = 1'b1;
                    shift    = in_valid;
                end else begin
                    shift    = !out_valid_q || out_ready;
                end
                if (shift) begin
                    if (in_ff) begin
                        ff_se = 1'b1;
                        ff_di = mode_q ? in_data : '0;
                    end else begin
                        mem_se = 1'b1;
                        mem_di = mode_q ? in_data : '0;
                    end
                    if (!mode_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = head;
                        out_last_d  = img_last;
                    end
                    if (chain_last) begin
                        cnt_d = '0;
                        if (in_ff && !NoMem) begin
                            state_d = StMem;
                        end else begin
                            state_d = mode_q ? StResume : StFlush;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                if (take) begin
                    state_d = StResume;
                end
            end
            StResume: begin
                if (!halted) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        halt_req_d = (state_d == StHalt) || (state_d == StFf) ||
                     (state_d == StMem) || (state_d == StFlush);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            halt_req_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            halt_req_q  <= halt_req_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign halt_req  = halt_req_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule
